// File: rtl/ota_trim_pkg.sv
// Shared types and helpers for the OTA offset-trim sequencer.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package ota_trim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SET,
        WAIT,
        DECIDE,
        DONE
    } state_t;

    // Width of an index/counter able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Settle-counter width: the counter is loaded with SETTLE_CYC-1.
    function automatic int cnt_width(input int settle_cyc);
        return idx_width(settle_cyc);
    endfunction

    // Midscale trim code (MSB set, rest clear), zero-extended to 8 bits.
    function automatic logic [7:0] midscale(input int trim_w);
        return 8'(1 << (trim_w - 1));
    endfunction

endpackage

// File: rtl/ota_trim_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; runs every cycle regardless of tile enable.
module ota_trim_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ota_trim_sar.sv
// SAR offset-trim sequencer for NUM_CH OTAs; optional OTA_TRIM_SAT_FLAG_EN adds sat_flag.
// Latency: NUM_CH*(1+TRIM_W*(SETTLE_CYC+2)) cycles busy per calibration; manual write lands next cycle.
// Backpressure: none; start and wr_en are dropped while busy, ena=0 freezes all state.
module ota_trim_sar
    import ota_trim_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int TRIM_W     = 6,
    parameter  int SETTLE_CYC = 8,
    localparam int CH_W       = idx_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic                     cmp_in,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [TRIM_W-1:0]        wr_data,
    output logic [CH_W-1:0]          ch_sel,
    output logic [NUM_CH*TRIM_W-1:0] trim_code,
`ifdef OTA_TRIM_SAT_FLAG_EN
    output logic [NUM_CH-1:0]        sat_flag,
`endif
    output logic                     busy,
    output logic                     done
);

    localparam int                BIT_W = idx_width(TRIM_W);
    localparam int                CNT_W = cnt_width(SETTLE_CYC);
    localparam logic [TRIM_W-1:0] MID   = TRIM_W'(midscale(TRIM_W));

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q;
    logic [BIT_W-1:0]    bit_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TRIM_W-1:0]   code_q [NUM_CH];
    logic [TRIM_W-1:0]   trial_code;
    logic                cmp_s;
    logic                last_ch;
    logic                wr_ok;

    ota_trim_cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_s)
    );

    assign last_ch = (ch_q == CH_W'(NUM_CH - 1));
    assign ch_sel  = ch_q;

    // Out-of-range write channels only exist when NUM_CH is not a power of two.
    if (NUM_CH == (1 << CH_W)) begin : g_wr_full
        assign wr_ok = 1'b1;
    end else begin : g_wr_part
        assign wr_ok = (wr_ch < CH_W'(NUM_CH));
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_pack
        assign trim_code[i*TRIM_W +: TRIM_W] = code_q[i];
    end

    // Code produced by a DECIDE step: resolve the current bit and raise the next
    // trial bit in the same edge, so the comparator sees each trial code for the
    // whole SET+WAIT window (SETTLE_CYC+1 cycles) before the decision.
    always_comb begin
        trial_code = code_q[ch_q];
        if (cmp_s) begin
            trial_code[bit_q] = 1'b0;
        end
        if (bit_q != '0) begin
            trial_code[bit_q - 1'b1] = 1'b1;
        end
    end

    // State register; ena low holds the FSM where it is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = SET;
            end
            SET: begin
                busy    = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                busy = 1'b1;
                if (bit_q != '0) begin
                    state_d = SET;
                end else if (!last_ch) begin
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: trim codes, channel/bit pointers and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                code_q[i] <= MID;
            end
            ch_q  <= '0;
            bit_q <= '0;
            cnt_q <= '0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    // A write coinciding with start still lands; LOAD then reclaims channel 0.
                    if (wr_en && wr_ok) begin
                        code_q[wr_ch] <= wr_data;
                    end
                    if (start) begin
                        ch_q <= '0;
                    end
                end
                LOAD: begin
                    // Clear the channel and raise the MSB trial bit in one step.
                    code_q[ch_q] <= MID;
                    bit_q        <= BIT_W'(TRIM_W - 1);
                end
                SET: begin
                    cnt_q <= CNT_W'(SETTLE_CYC - 1);
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DECIDE: begin
                    code_q[ch_q] <= trial_code;
                    if (bit_q != '0) begin
                        bit_q <= bit_q - 1'b1;
                    end else if (!last_ch) begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OTA_TRIM_SAT_FLAG_EN
    logic [NUM_CH-1:0] sat_q;

    // Flag channels whose final code hit either rail; cleared when a new run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (ena) begin
            if (state_q == IDLE && start) begin
                sat_q <= '0;
            end else if (state_q == DECIDE && bit_q == '0) begin
                sat_q[ch_q] <= (trial_code == '0) || (&trial_code);
            end
        end
    end

    assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_ota_trim_sar.sv
module tb_ota_trim_sar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic        rst_n, ena, start, wr_en, cmp_in, busy, done;
    logic [1:0]  wr_ch, ch_sel;
    logic [5:0]  wr_data;
    logic [23:0] trim_code;
    // Minimal instance: NUM_CH=1, TRIM_W=2, SETTLE_CYC=1.
    logic        start2, wr2_en, wr2_ch, cmp2, ch_sel2, busy2, done2;
    logic [1:0]  wr2_data, trim2;
`ifdef OTA_TRIM_SAT_FLAG_EN
    logic [3:0]  sat_flag;
    logic [0:0]  sat2;
`endif

    // Ideal comparator models: 1 iff the routed code exceeds the channel target.
    logic [5:0] tgt [4];
    logic [1:0] tgt2;
    logic [5:0] cur_code;
    assign cur_code = trim_code[ch_sel*6 +: 6];
    assign cmp_in   = (cur_code > tgt[ch_sel]);
    assign cmp2     = (trim2 > tgt2);

    ota_trim_sar dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp_in(cmp_in),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .ch_sel(ch_sel),
        .trim_code(trim_code),
`ifdef OTA_TRIM_SAT_FLAG_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy), .done(done)
    );

    ota_trim_sar #(.NUM_CH(1), .TRIM_W(2), .SETTLE_CYC(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .start(start2), .cmp_in(cmp2),
        .wr_en(wr2_en), .wr_ch(wr2_ch), .wr_data(wr2_data), .ch_sel(ch_sel2),
        .trim_code(trim2),
`ifdef OTA_TRIM_SAT_FLAG_EN
        .sat_flag(sat2),
`endif
        .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [23:0] code;
        int          len;
        logic [3:0]  sat;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq2[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor for the default instance: on each done pulse, compare against the scoreboard.
    initial begin : mon1
        int   blen;
        exp_t e;
        blen = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                blen = 0;
            end else begin
                if (busy) blen++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_done: done pulse with empty scoreboard");
                    end else begin
                        e = sbq.pop_front();
                        check("final_codes", trim_code, e.code);
                        check("busy_len", blen, e.len);
`ifdef OTA_TRIM_SAT_FLAG_EN
                        check("sat_flag", sat_flag, e.sat);
`endif
                    end
                    blen = 0;
                end
            end
        end
    end

    // Monitor for the minimal instance.
    initial begin : mon2
        int   blen;
        exp_t e;
        blen = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                blen = 0;
            end else begin
                if (busy2) blen++;
                if (done2) begin
                    if (sbq2.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_done2: done pulse with empty scoreboard");
                    end else begin
                        e = sbq2.pop_front();
                        check("final_code2", trim2, e.code);
                        check("busy_len2", blen, e.len);
                        check("ch_sel2", ch_sel2, 0);
`ifdef OTA_TRIM_SAT_FLAG_EN
                        check("sat_flag2", sat2, e.sat[0]);
`endif
                    end
                    blen = 0;
                end
            end
        end
    end

    // Wait (bounded) for every queued response to be consumed.
    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((sbq.size() != 0 || sbq2.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || sbq2.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d/%0d responses pending after %0d cycles",
                     sbq.size(), sbq2.size(), limit);
            sbq.delete();
            sbq2.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        start2 = 1'b0; wr2_en = 1'b0; wr2_ch = 1'b0; wr2_data = '0;
        tgt[0] = 6'd0; tgt[1] = 6'd17; tgt[2] = 6'd42; tgt[3] = 6'd63;
        tgt2 = 2'd2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset defaults.
        check("rst_trim_code", trim_code, {4{6'd32}});
        check("rst_ch_sel", ch_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_trim2", trim2, 2'd2);

        // Manual writes in IDLE; dut2 write targets a channel that does not exist.
        wr_en = 1'b1; wr_ch = 2'd2; wr_data = 6'd9;
        wr2_en = 1'b1; wr2_ch = 1'b1; wr2_data = 2'd1;
        @(negedge clk);
        wr_en = 1'b0; wr2_en = 1'b0;
        check("wr_idle", trim_code, {6'd32, 6'd9, 6'd32, 6'd32});
        check("wr_oob_ignored", trim2, 2'd2);

        // Full calibration; restart and write attempted mid-run at cycle 100.
        sbq.push_back('{code: {6'd63, 6'd42, 6'd17, 6'd0}, len: 244, sat: 4'b1001});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_ch = 2'd2; wr_data = 6'd5;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check("wr_busy_ignored", trim_code[17:12], 6'd9);
        drain(600);

        // Second calibration with ena held low for 50 cycles during the first WAIT.
        tgt[0] = 6'd5; tgt[1] = 6'd33; tgt[2] = 6'd60; tgt[3] = 6'd1;
        sbq.push_back('{code: {6'd1, 6'd60, 6'd33, 6'd5}, len: 294, sat: 4'b0000});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b0;
        check("hold_entry_codes", trim_code, {6'd63, 6'd42, 6'd17, 6'd32});
        repeat (50) @(negedge clk);
        check("hold_exit_codes", trim_code, {6'd63, 6'd42, 6'd17, 6'd32});
        check("hold_busy", busy, 1);
        check("hold_ch_sel", ch_sel, 0);
        ena = 1'b1;
        drain(700);

        // Minimal configuration, two targets.
        sbq2.push_back('{code: 24'd2, len: 7, sat: 4'b0000});
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        drain(50);
        tgt2 = 2'd1;
        sbq2.push_back('{code: 24'd1, len: 7, sat: 4'b0000});
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        drain(50);

        // Asynchronous reset in the middle of channel 1's first WAIT.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (64) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check("arst_trim_code", trim_code, {4{6'd32}});
        check("arst_ch_sel", ch_sel, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_trim2", trim2, 2'd2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ota_trim_sar.md
# ota_trim_sar

Digital offset-trim sequencer for a bank of NUM_CH five-transistor OTAs in the analog tile. It routes one OTA at a time to the shared comparator, which is selected through `ch_sel`. It then runs a successive-approximation search on that channel's trim DAC code and stores the result. It also accepts manual trim writes from the tile's digital pins and holds all trim codes static between calibrations.

## Interface
- NUM_CH, 4: number of OTA channels; legal 1..8.
- TRIM_W, 6: trim DAC code width per channel; legal 2..8.
- SETTLE_CYC, 8: clock cycles the analog path settles after each trim change; legal ≥1.

- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ena  in  1  tile enable; low freezes the FSM and settle counter in place.
- start  in  1  start full calibration; sampled only in IDLE.
- cmp_in  in  1  raw asynchronous comparator output; 1 means the trim code is too high.
- wr_en  in  1  manual trim write strobe; honoured only in IDLE.
- wr_ch  in  $clog2(NUM_CH) (min 1)  manual write channel index.
- wr_data  in  TRIM_W  manual write code.
- ch_sel  out  $clog2(NUM_CH) (min 1)  channel routed to the comparator.
- trim_code  out  NUM_CH*TRIM_W  packed codes; channel i is at [i*TRIM_W +: TRIM_W].
- busy  out  1  calibration in progress.
- done  out  1  one-cycle pulse when calibration completes.

## Operation
- Reset:
  - all trim codes = midscale (1<<(TRIM_W-1));
  - ch_sel=0, busy=0, done=0;
  - state IDLE, synchronizer flops cleared.
- cmp_in passes through a 2-flop synchronizer to give cmp_s; only cmp_s is used.
- FSM states are IDLE, LOAD, SET, WAIT, DECIDE, DONE.
- IDLE:
  - start=1 → LOAD with ch=0.
  - wr_en=1 writes wr_data into channel wr_ch.
  - A write to wr_ch ≥ NUM_CH is ignored.
  - If start and wr_en arrive in the same cycle, the write applies first and calibration then overwrites channel 0 in LOAD.
- LOAD: code[ch]=0, bit=TRIM_W-1, ch_sel=ch → SET.
- SET: code[ch][bit]=1, settle counter = SETTLE_CYC-1 → WAIT.
- WAIT: counter decrements each cycle; when it reaches 0 → DECIDE.
- DECIDE:
  - If cmp_s=1, clear code[ch][bit].
  - If bit>0: bit−1 → SET.
  - Else if ch<NUM_CH-1: ch+1 → LOAD.
  - Else → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- busy=1 in every state except IDLE and DONE.
- While busy, start and wr_en are ignored.
- Channels other than the one under calibration keep their codes.
- ena=0 holds state, counter, codes and outputs. The synchronizer keeps running.
- Reset mid-calibration restores all reset values immediately, including codes to midscale; partial results are discarded.
- Ideal comparator model: cmp=1 iff code > T. The final code is exactly T for T in 0..2^TRIM_W−1.

## Timing
- start is accepted at edge k; LOAD occupies cycle k+1 and busy rises at edge k+1.
- Cycles per bit = SETTLE_CYC+2 (SET, WAIT, DECIDE).
- Cycles per channel = 1 + TRIM_W*(SETTLE_CYC+2).
- Busy length = NUM_CH*(1+TRIM_W*(SETTLE_CYC+2)); with defaults this is 244 cycles.
- done rises in the cycle after the last DECIDE.
- A manual write lands on trim_code one cycle after the wr_en edge.
- The comparator decision uses cmp_s sampled in DECIDE. The comparator sees the new code for SETTLE_CYC+1 cycles before the decision. This covers the 2-cycle synchronizer latency whenever SETTLE_CYC ≥ 1.

## Configuration
- OTA_TRIM_SAT_FLAG_EN defined:
  - Adds output sat_flag (out, NUM_CH bits).
  - sat_flag[i] is set when channel i finishes calibration with code all-zeros or all-ones.
  - All bits clear on reset and at start acceptance.
  - A manual write does not change sat_flag.
- Undefined: the port is absent and no saturation logic is built.

## Structure
- Package ota_trim_pkg holds:
  - the state enum (IDLE, LOAD, SET, WAIT, DECIDE, DONE);
  - a helper returning the settle-counter width, $clog2(SETTLE_CYC) with minimum 1;
  - the midscale reset-code function.
- One sub-module, ota_trim_cmp_sync: 2-flop synchronizer with asynchronous active-low reset to 0.
- The tile top-level maps start, wr_en, wr_ch and wr_data onto ui_in/uio_in, and trim_code onto uo_out/uio_out. ch_sel drives the analog mux select.

## Test plan
- Reset release, defaults:
  - trim_code = 4×6'd32, ch_sel=0, busy=0, done=0.
  - Assert rst_n low mid-WAIT; all return to these values asynchronously.
- Calibration with comparator model targets T={0,17,42,63}, defaults:
  - busy high for exactly 244 cycles, then one done pulse.
  - Final codes {0,17,42,63}.
  - With OTA_TRIM_SAT_FLAG_EN, sat_flag=4'b1001.
- Manual write in IDLE, wr_ch=2, wr_data=6'd9 → channel 2 reads 9 next cycle.
  - The same write issued while busy → no change.
- Start pulsed again at cycle 100 of a calibration → ignored; total busy length is still 244.
- Hold ena=0 for 50 cycles mid-WAIT → state and codes frozen; busy length extends to exactly 294; final codes unchanged.
- NUM_CH=1, TRIM_W=2, SETTLE_CYC=1, T=2 → busy for 7 cycles, final code 2'd2.
